// File: rtl/pid_power_ctrl.sv
`timescale 1ns/1ps
// PID motor-power controller: one shared multiplier, six-state schedule per sample.
// Define PID_ANTI_WINDUP_EN to hold the integrator while the output is saturated in the error's direction.
module pid_power_ctrl #(
    parameter int SIZE      = 16,
    parameter int GAIN_W    = 12,
    parameter int SHIFT     = 8,
    parameter int OUT_LIMIT = 1023,
    parameter int INT_LIMIT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     clear,
    input  logic signed [SIZE-1:0]   setpoint,
    input  logic signed [SIZE-1:0]   measurement,
    input  logic        [GAIN_W-1:0] kp,
    input  logic        [GAIN_W-1:0] ki,
    input  logic        [GAIN_W-1:0] kd,
    output logic signed [SIZE-1:0]   motor_power,
    output logic                     out_valid,
    output logic                     busy
);

    localparam int ERR_W  = SIZE + 1;
    localparam int DER_W  = SIZE + 2;
    localparam int INT_W  = 32;
    localparam int ACC_W  = 48;
    localparam int PROD_W = GAIN_W + 1 + INT_W;

    localparam logic signed [INT_W:0]    INT_HI = (INT_W+1)'(INT_LIMIT);
    localparam logic signed [INT_W:0]    INT_LO = -(INT_W+1)'(INT_LIMIT);
    localparam logic signed [ACC_W-1:0]  OUT_HI = ACC_W'(OUT_LIMIT);
    localparam logic signed [ACC_W-1:0]  OUT_LO = -ACC_W'(OUT_LIMIT);
    localparam logic signed [SIZE-1:0]   MP_HI  = SIZE'(OUT_LIMIT);
    localparam logic signed [SIZE-1:0]   MP_LO  = -SIZE'(OUT_LIMIT);

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT} state_t;

    state_t                   state;
    logic signed [SIZE-1:0]   sp_q, meas_q;
    logic        [GAIN_W-1:0] kp_q, ki_q, kd_q;
    logic signed [ERR_W-1:0]  err_q, err_prev;
    logic signed [DER_W-1:0]  deriv_q;
    logic signed [INT_W-1:0]  integ;
    logic                     first;
    logic signed [ACC_W-1:0]  acc;

    logic signed [ERR_W-1:0]  err_next;
    logic signed [INT_W:0]    integ_sum;
    logic signed [INT_W-1:0]  integ_next;
    logic signed [DER_W-1:0]  deriv_next;
    logic                     hold_integ;
    logic signed [PROD_W-1:0] mul_a, mul_b, product;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [SIZE-1:0]   out_next;

    // Error is one bit wider than the inputs so setpoint - measurement can never wrap.
    assign err_next   = {sp_q[SIZE-1], sp_q} - {meas_q[SIZE-1], meas_q};
    assign integ_sum  = {integ[INT_W-1], integ} + {{(INT_W+1-ERR_W){err_next[ERR_W-1]}}, err_next};
    assign integ_next = (integ_sum > INT_HI) ? INT_HI[INT_W-1:0] :
                        (integ_sum < INT_LO) ? INT_LO[INT_W-1:0] : integ_sum[INT_W-1:0];
    assign deriv_next = first ? '0 :
                        ({err_next[ERR_W-1], err_next} - {err_prev[ERR_W-1], err_prev});

`ifdef PID_ANTI_WINDUP_EN
    assign hold_integ = ((motor_power == MP_HI) && (err_next > 0)) ||
                        ((motor_power == MP_LO) && (err_next < 0));
`else
    assign hold_integ = 1'b0;
`endif

    // Shared multiplier: the state selects which gain/term pair feeds it this cycle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MP: begin
                mul_a = {{(PROD_W-GAIN_W){1'b0}}, kp_q};
                mul_b = {{(PROD_W-ERR_W){err_q[ERR_W-1]}}, err_q};
            end
            S_MI: begin
                mul_a = {{(PROD_W-GAIN_W){1'b0}}, ki_q};
                mul_b = {{(PROD_W-INT_W){integ[INT_W-1]}}, integ};
            end
            S_MD: begin
                mul_a = {{(PROD_W-GAIN_W){1'b0}}, kd_q};
                mul_b = {{(PROD_W-DER_W){deriv_q[DER_W-1]}}, deriv_q};
            end
            default: ;
        endcase
    end

    assign product  = mul_a * mul_b;
    assign acc_shr  = acc >>> SHIFT;
    assign out_next = (acc_shr > OUT_HI) ? MP_HI :
                      (acc_shr < OUT_LO) ? MP_LO : acc_shr[SIZE-1:0];

    // NOTE: all state is updated with non-blocking assignments so every register samples
    // pre-edge values, independent of statement order inside this block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sp_q        <= '0;
            meas_q      <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            err_q       <= '0;
            err_prev    <= '0;
            deriv_q     <= '0;
            integ       <= '0;
            first       <= 1'b1;
            acc         <= '0;
            motor_power <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else if (clear) begin
            state       <= S_IDLE;
            integ       <= '0;
            err_prev    <= '0;
            first       <= 1'b1;
            motor_power <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sp_q   <= setpoint;
                        meas_q <= measurement;
                        kp_q   <= kp;
                        ki_q   <= ki;
                        kd_q   <= kd;
                        busy   <= 1'b1;
                        state  <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_q    <= err_next;
                    deriv_q  <= deriv_next;
                    err_prev <= err_next;
                    first    <= 1'b0;
                    acc      <= '0;
                    if (!hold_integ)
                        integ <= integ_next;
                    state    <= S_MP;
                end
                S_MP, S_MI, S_MD: begin
                    acc   <= acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
                    state <= (state == S_MP) ? S_MI : (state == S_MI) ? S_MD : S_OUT;
                end
                S_OUT: begin
                    motor_power <= out_next;
                    out_valid   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pid_power_ctrl.md
Name: pid_power_ctrl

Overview:
- Closed-loop controller directly upstream of the motor driver.
- Takes a signed setpoint and measurement once per sample strobe and computes a fixed-point PID output.
- Clamps the result and holds it as the signed motor_power word the motor driver consumes (magnitude ≤1023 maps onto duty, sign onto direction).
- Uses one shared multiplier over a fixed multi-cycle schedule.

Parameters:
SIZE, 16, width of setpoint, measurement and motor_power (signed two's complement)
GAIN_W, 12, width of unsigned gain inputs kp/ki/kd
SHIFT, 8, fractional bits of gains (256 = 1.0)
OUT_LIMIT, 1023, symmetric output clamp magnitude
INT_LIMIT, 65535, symmetric integrator clamp magnitude

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  sample strobe; accepted only when busy=0
clear  input  1  synchronous; zero integrator, history and output, abort computation
setpoint  input  SIZE  signed target
measurement  input  SIZE  signed feedback
kp  input  GAIN_W  unsigned proportional gain
ki  input  GAIN_W  unsigned integral gain
kd  input  GAIN_W  unsigned derivative gain
motor_power  output  SIZE  signed registered output to the motor driver
out_valid  output  1  one-cycle pulse when motor_power updates
busy  output  1  high while a sample is in flight

Behaviour:
- Clock, reset: one clock clk; rst is asynchronous, active-high.
- Reset values: motor_power=0, out_valid=0, busy=0, integ=0, err_prev=0, first=1, state IDLE. Reset mid-computation discards the sample.
- States: IDLE → ERR → MP → MI → MD → OUT → IDLE.
- Acceptance: in_valid=1 in IDLE at edge k latches setpoint, measurement and gains; busy=1 from k.
  - Gain changes after k do not affect the sample.
  - in_valid while busy=1 is dropped; no queueing.
- ERR (edge k+1):
  - err = setpoint − measurement, SIZE+1 bits signed, no wrap.
  - integ = clamp(integ + err, ±INT_LIMIT), 32-bit signed.
  - deriv = first ? 0 : err − err_prev, SIZE+2 bits.
  - err_prev ← err; first ← 0.
- MP/MI/MD (edges k+2..k+4): acc (48-bit signed) accumulates kp·err, then ki·integ, then kd·deriv. Gains are zero-extended to signed.
- OUT (edge k+5):
  - motor_power ← clamp(acc >>> SHIFT, ±OUT_LIMIT), using an arithmetic shift (floor).
  - out_valid=1 for exactly the cycle after edge k+5; busy=0 in that same cycle.
  - Earliest next acceptance is at edge k+6 (in_valid sampled while out_valid=1 is accepted).
- clear=1 at any edge:
  - Forces IDLE; integ=0, err_prev=0, first=1, motor_power=0, out_valid=0, busy=0.
  - Takes priority over in_valid at the same edge.
- motor_power holds its value between updates. It is never driven outside [−OUT_LIMIT, +OUT_LIMIT].

Optional Feature:
PID_ANTI_WINDUP_EN
- Defined: in ERR, integ is left unchanged when the current motor_power equals +OUT_LIMIT and err>0, or equals −OUT_LIMIT and err<0 (conditional integration).
- Undefined: integ always updates, bounded only by INT_LIMIT.
- Timing and all other behaviour are identical in both builds.

Test Plan:
1. Assert rst mid-computation (at edge k+3) → motor_power=0, busy=0, out_valid=0 asynchronously; next sample treats deriv as 0.
2. kp=256, ki=kd=0, setpoint=500, measurement=0 → out_valid pulse 5 edges after accept, motor_power=500. Then setpoint=2000 → 1023; setpoint=0, measurement=2000 → −1023.
3. ki=256, kp=kd=0, err=100 for three samples → 100, 200, 300. ki=1, err=30000 for three samples → integ 30000, 60000, 65535; outputs 117, 234, 255.
4. kd=256, kp=ki=0: err=100 then err=300 → 0 (first sample), then 200. clear, then err=50 → 0.
5. in_valid at edges k and k+2 → exactly one out_valid; in_valid held continuously → one update every 6 cycles. clear at k+3 → no out_valid, motor_power=0.
6. PID_ANTI_WINDUP_EN: kp=256, ki=256, err=2000 for two samples, then err=−100 → integ stays 2000 after sample 2, not 4000. Without the macro → integ=4000.
